// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_pkg
//  Desc     : Shared types and helpers for the 1R1W byte-enable RAM block:
//             sequencer state enum, address-width helper, configuration check.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

   // Sequencer states: zero-fill after reset, then normal operation.
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // Address width for a given depth.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Legal configuration: whole bytes per word, power-of-two depth of at least 2.
   function automatic bit cfg_ok(input int depth, input int width);
      return (width > 0) && ((width % 8) == 0) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram2p1r1wbe_core.sv
`default_nettype none
// ============================================================================
//  Module   : ram2p1r1wbe_core
//  Desc     : Behavioural storage array: one registered read port, one
//             byte-masked write port, no reset. Read-first on collisions.
//             Drop-in point for a vendor macro.
//  Revision : 1.0 - initial release
// ============================================================================
module ram2p1r1wbe_core
   import ram_pkg::*;
#(
   parameter  int DEPTH = 512,
   parameter  int WIDTH = 64,
   localparam int AW    = addr_width(DEPTH),
   localparam int NB    = WIDTH / 8
) (
   input  logic             clk,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [NB-1:0]    be_i
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Registered read; holds its value while the port is idle.
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   // Byte-masked write; disabled bytes keep their contents.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ram2p1r1wbe_init.sv
`default_nettype none
// ============================================================================
//  Module   : ram2p1r1wbe_init
//  Desc     : 1R1W SRAM with active-high byte write enables, post-reset
//             zero-fill sequencer, same-address write-to-read forwarding and
//             an optional output pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
module ram2p1r1wbe_init
   import ram_pkg::*;
#(
   parameter  int DEPTH  = 512,
   parameter  int WIDTH  = 64,
   parameter  int OUTREG = 0,
   parameter  int CLEAR  = 1,
   parameter  int BYPASS = 1,
   localparam int AW     = addr_width(DEPTH),
   localparam int NB     = WIDTH / 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce1,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd1,
   input  logic             ce2,
   input  logic             we2,
   input  logic [AW-1:0]    wa2,
   input  logic [WIDTH-1:0] wd2,
   input  logic [NB-1:0]    bwe2,
   output logic             Ready
);

   if (!cfg_ok(DEPTH, WIDTH)) begin : g_cfg_err
      $error("ram2p1r1wbe_init: WIDTH must be a multiple of 8 and DEPTH a power of two >= 2");
   end

   state_e           state_q;
   logic [AW-1:0]    cnt_q;
   logic             ready_q;

   logic             clr_act;
   logic             run_act;
   logic             ext_wr;
   logic             core_re;
   logic             core_we;
   logic [AW-1:0]    core_wa;
   logic [WIDTH-1:0] core_wd;
   logic [NB-1:0]    core_be;
   logic [WIDTH-1:0] core_rdata;

   logic             hit;
   logic [NB-1:0]    byp_mask_q;
   logic [WIDTH-1:0] byp_data_q;
   logic [WIDTH-1:0] merged;

   // Clear/run sequencer; Ready rises on the edge that retires the last clear write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= (CLEAR != 0) ? ST_CLEAR : ST_RUN;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // External traffic is honoured only once Ready is visible and reset is low.
   assign clr_act = (state_q == ST_CLEAR) && !reset;
   assign run_act = ready_q && !reset;
   assign ext_wr  = run_act && ce2 && we2;
   assign core_re = run_act && ce1;

   // The zero-fill sequencer owns the write port while clearing.
   assign core_we = clr_act || ext_wr;
   assign core_wa = clr_act ? cnt_q : wa2;
   assign core_wd = clr_act ? '0    : wd2;
   assign core_be = clr_act ? '1    : bwe2;

   ram2p1r1wbe_core #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .re_i    (core_re),
      .raddr_i (ra1),
      .rdata_o (core_rdata),
      .we_i    (core_we),
      .waddr_i (core_wa),
      .wdata_i (core_wd),
      .be_i    (core_be)
   );

   // Same-address collision: the core returns old data, so remember which bytes to patch.
   assign hit = (BYPASS != 0) && core_re && ext_wr && (ra1 == wa2);

   // Capture forwarding bytes alongside each read so a held rd1 stays consistent.
   always_ff @(posedge clk) begin
      if (reset) begin
         byp_mask_q <= '0;
         byp_data_q <= '0;
      end else if (core_re) begin
         byp_mask_q <= hit ? bwe2 : '0;
         byp_data_q <= wd2;
      end
   end

   // Patch forwarded bytes over the core's read-first data.
   always_comb begin
      merged = core_rdata;
      for (int b = 0; b < NB; b++) begin
         if (byp_mask_q[b]) begin
            merged[b*8 +: 8] = byp_data_q[b*8 +: 8];
         end
      end
   end

   if (OUTREG != 0) begin : g_outreg
      logic             rd_vld_q;
      logic [WIDTH-1:0] out_q;

      // Second stage loads only behind a real read, otherwise holds.
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_vld_q <= 1'b0;
            out_q    <= '0;
         end else begin
            rd_vld_q <= core_re;
            if (rd_vld_q) begin
               out_q <= merged;
            end
         end
      end

      assign rd1 = out_q;
   end else begin : g_noreg
      logic have_q;

      // Masks the unreset core register until the first read after reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            have_q <= 1'b0;
         end else if (core_re) begin
            have_q <= 1'b1;
         end
      end

      assign rd1 = have_q ? merged : '0;
   end

   assign Ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ram2p1r1wbe_init.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram2p1r1wbe_init
//  Desc     : Self-checking bench for ram2p1r1wbe_init. Three configurations
//             share one stimulus stream; an array-level reference model
//             predicts Ready and rd1 for each of them every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram2p1r1wbe_init;

   localparam int NI = 3;
   localparam int P_DEPTH  [NI] = '{512, 16, 16};
   localparam int P_OUTREG [NI] = '{0,   1,  0};
   localparam int P_CLEAR  [NI] = '{1,   1,  0};
   localparam int P_BYPASS [NI] = '{1,   0,  1};

   logic        clk = 1'b0;
   logic        reset;
   logic        ce1, ce2, we2;
   logic [8:0]  ra, wa;
   logic [63:0] wd;
   logic [7:0]  bwe;

   logic [63:0] rd_w  [NI];
   logic        rdy_w [NI];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [63:0] m_mem [NI][512];
   bit          m_kn  [NI][512];
   logic        m_rdy [NI];
   int          m_clr [NI];
   logic [63:0] m_rd  [NI];
   bit          m_rdk [NI];
   logic [63:0] m_s1  [NI];
   bit          m_s1k [NI];
   bit          m_s1v [NI];

   always #5 clk = ~clk;

   ram2p1r1wbe_init #(.DEPTH(512), .WIDTH(64), .OUTREG(0), .CLEAR(1), .BYPASS(1)) u0 (
      .clk(clk), .reset(reset), .ce1(ce1), .ra1(ra), .rd1(rd_w[0]),
      .ce2(ce2), .we2(we2), .wa2(wa), .wd2(wd), .bwe2(bwe), .Ready(rdy_w[0]));

   ram2p1r1wbe_init #(.DEPTH(16), .WIDTH(64), .OUTREG(1), .CLEAR(1), .BYPASS(0)) u1 (
      .clk(clk), .reset(reset), .ce1(ce1), .ra1(ra[3:0]), .rd1(rd_w[1]),
      .ce2(ce2), .we2(we2), .wa2(wa[3:0]), .wd2(wd), .bwe2(bwe), .Ready(rdy_w[1]));

   ram2p1r1wbe_init #(.DEPTH(16), .WIDTH(64), .OUTREG(0), .CLEAR(0), .BYPASS(1)) u2 (
      .clk(clk), .reset(reset), .ce1(ce1), .ra1(ra[3:0]), .rd1(rd_w[2]),
      .ce2(ce2), .we2(we2), .wa2(wa[3:0]), .wd2(wd), .bwe2(bwe), .Ready(rdy_w[2]));

   // One clock edge of the reference model for instance k, from the current inputs.
   task automatic model_edge(input int k);
      int          a_r, a_w;
      logic [63:0] rv;
      bit          rk;
      if (reset) begin
         m_rdy[k] = 1'b0; m_clr[k] = 0; m_rd[k] = '0; m_rdk[k] = 1'b1; m_s1v[k] = 1'b0;
         return;
      end
      if (!m_rdy[k]) begin
         m_s1v[k] = 1'b0;
         if (P_CLEAR[k] != 0) begin
            m_clr[k]++;
            if (m_clr[k] == P_DEPTH[k]) begin
               for (int i = 0; i < P_DEPTH[k]; i++) begin
                  m_mem[k][i] = '0; m_kn[k][i] = 1'b1;
               end
               m_rdy[k] = 1'b1;
            end
         end else begin
            m_rdy[k] = 1'b1;
         end
         return;
      end
      a_r = int'(ra) % P_DEPTH[k];
      a_w = int'(wa) % P_DEPTH[k];
      rv  = m_mem[k][a_r];
      rk  = m_kn[k][a_r];
      if (ce2 && we2 && ce1 && a_r == a_w && P_BYPASS[k] != 0) begin
         for (int b = 0; b < 8; b++) if (bwe[b]) rv[b*8 +: 8] = wd[b*8 +: 8];
         if (bwe == 8'hFF) rk = 1'b1;
      end
      if (ce2 && we2) begin
         for (int b = 0; b < 8; b++) if (bwe[b]) m_mem[k][a_w][b*8 +: 8] = wd[b*8 +: 8];
         if (bwe == 8'hFF) m_kn[k][a_w] = 1'b1;
      end
      if (P_OUTREG[k] != 0) begin
         if (m_s1v[k]) begin m_rd[k] = m_s1[k]; m_rdk[k] = m_s1k[k]; end
         m_s1v[k] = ce1;
         if (ce1) begin m_s1[k] = rv; m_s1k[k] = rk; end
      end else if (ce1) begin
         m_rd[k] = rv; m_rdk[k] = rk;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         assert (rdy_w[k] === m_rdy[k]) else begin
            n_errors++;
            $error("FAIL ready[u%0d] observed %b expected %b", k, rdy_w[k], m_rdy[k]);
         end
         if (m_rdk[k]) begin
            n_checks++;
            assert (rd_w[k] === m_rd[k]) else begin
               n_errors++;
               $error("FAIL rd1[u%0d] observed %h expected %h", k, rd_w[k], m_rd[k]);
            end
         end
      end
   endtask

   task automatic expect64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      for (int k = 0; k < NI; k++) model_edge(k);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      ce1 = 1'b0; ce2 = 1'b0; we2 = 1'b0; bwe = '0;
   endtask

   task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
      ce2 = 1'b1; we2 = 1'b1; wa = a; wd = d; bwe = m;
      step();
      idle();
   endtask

   task automatic do_read(input logic [8:0] a);
      ce1 = 1'b1; ra = a;
      step();
      idle();
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 512; i++) begin m_mem[k][i] = '0; m_kn[k][i] = 1'b0; end
         m_rdy[k] = 1'b0; m_clr[k] = 0; m_rd[k] = '0; m_rdk[k] = 1'b0;
         m_s1[k] = '0; m_s1k[k] = 1'b0; m_s1v[k] = 1'b0;
      end
      ra = '0; wa = '0; wd = '0;
      idle();

      // reset, then interrupt the clear at cycle 200 with a dropped write at cycle 100
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (c == 100) begin
            ce2 = 1'b1; we2 = 1'b1; wa = 9'd5; wd = 64'hCAFE_F00D_1234_5678; bwe = 8'hFF;
         end
         step();
         idle();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 512; c++) begin
         step();
         if (c == 510) expect64("ready_before_last_clear", {63'd0, rdy_w[0]}, 64'd0);
         if (c == 511) expect64("ready_after_clear", {63'd0, rdy_w[0]}, 64'd1);
      end

      // every word reads back zero
      for (int a = 0; a < 512; a++) do_read(9'(a));

      // byte masking
      do_write(9'd5, 64'h1122_3344_5566_7788, 8'hFF);
      do_write(9'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      do_read(9'd5);
      expect64("bytemask_u0", rd_w[0], 64'h1122_3344_AAAA_AAAA);
      expect64("bytemask_u2", rd_w[2], 64'h1122_3344_AAAA_AAAA);

      // same-address collision on addr 7
      ce1 = 1'b1; ra = 9'd7;
      ce2 = 1'b1; we2 = 1'b1; wa = 9'd7; wd = '1; bwe = 8'h03;
      step();
      idle();
      expect64("collision_bypass", rd_w[0], 64'h0000_0000_0000_FFFF);
      step();
      expect64("collision_readfirst", rd_w[1], 64'd0);

      // output register latency
      do_write(9'd3, 64'hDEAD, 8'hFF);
      do_read(9'd3);
      expect64("outreg_lat1", rd_w[1], 64'd0);
      expect64("noreg_lat1", rd_w[0], 64'hDEAD);
      step();
      expect64("outreg_lat2", rd_w[1], 64'hDEAD);
      for (int c = 0; c < 3; c++) step();
      expect64("outreg_hold", rd_w[1], 64'hDEAD);

      // back-to-back writes then reads, no stalls
      for (int a = 0; a < 16; a++) begin
         ce2 = 1'b1; we2 = 1'b1; wa = 9'(a); wd = {$urandom, $urandom}; bwe = 8'hFF;
         step();
      end
      idle();
      for (int a = 0; a < 16; a++) begin
         ce1 = 1'b1; ra = 9'(a);
         step();
      end
      idle();
      step();
      step();

      // randomized traffic with frequent collisions
      for (int c = 0; c < 600; c++) begin
         ce1 = 1'($urandom);
         ce2 = 1'($urandom);
         we2 = ($urandom_range(0, 3) != 0);
         ra  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
         wa  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
         wd  = {$urandom, $urandom};
         bwe = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         step();
      end
      idle();
      step();
      step();

      // CLEAR=0 instance is ready one edge after reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      expect64("noclear_ready", {63'd0, rdy_w[2]}, 64'd1);
      expect64("clear_not_ready", {63'd0, rdy_w[0]}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram2p1r1wbe_init.md
# ram2p1r1wbe_init

Parametrised one-read/one-write SRAM block with per-byte write enables, for cache tag/data arrays and branch-predictor tables. Wraps a behavioural storage core and adds a post-reset zero-fill sequencer, same-address write-to-read forwarding and an optional output pipeline register. It replaces the fixed-size, active-low-strobe vendor wrappers with one synthesizable model whose strobes are active-high and whose contents are known after reset.

## Interface
- DEPTH, 512: number of words; power of two, at least 2.
- WIDTH, 64: word width in bits; multiple of 8.
- OUTREG, 0: 1 adds a registered output stage, making read latency 2.
- CLEAR, 1: 1 zero-fills the whole array after reset.
- BYPASS, 1: 1 forwards same-cycle, same-address write data to the read port.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ce1  in  1  read port enable.
- ra1  in  $clog2(DEPTH)  read address.
- rd1  out  WIDTH  read data.
- ce2  in  1  write port enable.
- we2  in  1  write strobe; a write occurs only when ce2 and we2 are both 1.
- wa2  in  $clog2(DEPTH)  write address.
- wd2  in  WIDTH  write data.
- bwe2  in  WIDTH/8  byte write enables; bit i covers wd2[8i+7:8i].
- Ready  out  1  array initialised; external accesses are honoured.

## Operation
- **States:** CLEAR and RUN.
- **Reset:** reset=1 forces state CLEAR (or RUN when CLEAR=0), clears the clear counter, and drives rd1=0, the output stage register =0 and Ready=0.
- **CLEAR state:**
  - Writes all-zero to address cnt each cycle, all bytes enabled, then increments cnt.
  - When cnt=DEPTH-1 is written, moves to RUN on the next edge.
  - Clearing takes exactly DEPTH cycles.
  - External ce1/ce2 are ignored; rd1 holds 0.
- **RUN state:** Ready=1. No exit other than reset.
- **Reset during CLEAR:** restarts from cnt=0. Partially cleared words have no significance.
- **CLEAR=0:** state RUN and Ready=1 from the first edge after reset deasserts. Array contents are undefined (X in simulation).
- **Write (RUN):** for each i with bwe2[i]=1, mem[wa2] byte i takes wd2 byte i. Bytes with bwe2[i]=0 are unchanged. bwe2=0 with we2=1 is a legal no-op.
- **Read (RUN):** with ce1=1, ra1 is sampled and the stored word is returned. With ce1=0, rd1 holds its last value.
- **Read and write to the same address in the same cycle:**
  - BYPASS=1: the returned word is the merge, taking wd2 bytes where bwe2=1 and old bytes elsewhere.
  - BYPASS=0: the returned word is the old contents (read-first).
- **Different addresses:** a simultaneous read and write are fully independent.

## Timing
- OUTREG=0: read data appears on rd1 one edge after ce1 is sampled.
- OUTREG=1: read data appears two edges after ce1 is sampled. The output stage loads only when its preceding stage holds a valid read; otherwise it holds.
- Write latency is one edge. A read of the same address on the next cycle returns the new data, independent of BYPASS.
- Ready rises on the edge that ends the last clear write, DEPTH cycles after reset deasserts.
- A request presented in the cycle Ready first reads 1 is honoured.
- A request presented while Ready=0 is dropped. No backpressure exists; the requester must wait on Ready.

## Structure
- A shared package ram_pkg holds:
  - the state enum (CLEAR, RUN);
  - an address-width helper equal to $clog2(DEPTH);
  - an elaboration check that WIDTH%8==0 and DEPTH is a power of two.
- Sub-module ram2p1r1wbe_core: the behavioural array only, with a registered read, byte-masked write and no reset.
  - The top level muxes the clear sequencer onto the core's write port.
  - The bypass merge and the output stage sit in the top level.
  - A vendor macro can replace the core without touching the top level.

## Test plan
- **Clear sequence:** DEPTH=512, CLEAR=1, reset for 1 cycle, then hold idle → Ready=0 for 512 cycles then 1. Reading all 512 addresses returns 0.
- **Byte masking:** write 0x1122334455667788 to addr 5 with bwe2=0xFF, then write 0xAAAAAAAAAAAAAAAA with bwe2=0x0F → read of addr 5 returns 0x11223344AAAAAAAA.
- **Same-address collision:** read and write addr 7 in the same cycle (old 0, wd2=all-ones, bwe2=0x03).
  - BYPASS=1: rd1=0x000000000000FFFF.
  - BYPASS=0: rd1=0.
- **OUTREG latency:** OUTREG=1, read addr 3 holding 0xDEAD → 0xDEAD on rd1 exactly 2 cycles after ce1. With ce1=0 afterwards, rd1 holds 0xDEAD.
- **Reset mid-clear:** assert reset at clear cycle 200 → the counter restarts and Ready rises 512 cycles after the second reset. A write attempted at cycle 100 has no effect.
- **CLEAR=0:** Ready=1 one cycle after reset. Back-to-back writes to addrs 0..15 then reads of them return the written data with no stalls.
